// File: rtl/fpu_addsub.sv
// Floating-point add/subtract with round-to-nearest-even, full subnormal/Inf/NaN handling.
// Six-state FSM: result valid 4 edges after accept; holds result while out_ready is low.
module fpu_addsub #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [2:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int EW = EXP_W + 1;
  localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q, b_q;
  logic            big_sign_q, eff_sub_q, zero_q;
  logic [EW-1:0]   big_e_q, norm_e_q;
  logic [SW-1:0]   big_sig_q, sml_sig_q, norm_sig_q;
  logic [SW:0]     sum_q;
  logic            out_valid_q;
  logic [W-1:0]    result_q;
  logic [2:0]      flags_q;

  logic [EXP_W-1:0]     ea, eb, ea_eff, eb_eff, e_big, e_sml, diff;
  logic [SW-1:0]        sig_a, sig_b, sig_big, sig_sml, shifted;
  logic                 a_big, lost;
  logic [31:0]          shamt, lz, maxsh, sh;
  logic [SW-1:0]        big_sig_d, sml_sig_d, norm_sig_d;
  logic [EW-1:0]        big_e_d, norm_e_d, exp_field, rnd_e;
  logic                 big_sign_d, eff_sub_d, zero_d;
  logic [SW:0]          sum_d;
  logic [EW+MAN_W-1:0]  rnd;
  logic                 inc, inexact, nan_a, nan_b, inf_a, inf_b, snan;
  logic [W-1:0]         res_d;
  logic [2:0]           flags_d;

  always_comb begin
    // Unpack: subnormals use effective exponent 1 with a zero hidden bit.
    ea      = a_q[W-2:MAN_W];
    eb      = b_q[W-2:MAN_W];
    ea_eff  = (ea == '0) ? EXP_W'(1) : ea;
    eb_eff  = (eb == '0) ? EXP_W'(1) : eb;
    sig_a   = {(ea != '0), a_q[MAN_W-1:0], 3'b000};
    sig_b   = {(eb != '0), b_q[MAN_W-1:0], 3'b000};
    a_big   = (a_q[W-2:0] >= b_q[W-2:0]);
    e_big   = a_big ? ea_eff : eb_eff;
    e_sml   = a_big ? eb_eff : ea_eff;
    sig_big = a_big ? sig_a : sig_b;
    sig_sml = a_big ? sig_b : sig_a;
    diff    = e_big - e_sml;
    shamt   = (32'(diff) > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : 32'(diff);
    shifted = sig_sml >> shamt;
    lost    = |(sig_sml & ~({SW{1'b1}} << shamt));
    big_sig_d  = sig_big;
    sml_sig_d  = {shifted[SW-1:1], shifted[0] | lost};
    big_e_d    = {1'b0, e_big};
    big_sign_d = a_big ? a_q[W-1] : b_q[W-1];
    eff_sub_d  = a_q[W-1] ^ b_q[W-1];

    sum_d = eff_sub_q ? ({1'b0, big_sig_q} - {1'b0, sml_sig_q})
                      : ({1'b0, big_sig_q} + {1'b0, sml_sig_q});

    // Leading-zero count; left shift is clamped so the exponent stays >= 1.
    lz = 32'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum_q[i]) lz = 32'(SW - 1 - i);
    end
    maxsh = 32'(big_e_q) - 32'd1;
    sh    = (lz < maxsh) ? lz : maxsh;
    if (sum_q[SW]) begin
      norm_sig_d = {sum_q[SW:2], |sum_q[1:0]};
      norm_e_d   = big_e_q + EW'(1);
    end else begin
      norm_sig_d = sum_q[SW-1:0] << sh;
      norm_e_d   = big_e_q - EW'(sh);
    end
    zero_d = (sum_q == '0);

    // Adding inc to {exp, mantissa} folds both renormalisation carries into the exponent.
    inc       = norm_sig_q[2] & (norm_sig_q[1] | norm_sig_q[0] | norm_sig_q[3]);
    inexact   = |norm_sig_q[2:0];
    exp_field = norm_sig_q[SW-1] ? norm_e_q : '0;
    rnd       = {exp_field, norm_sig_q[SW-2:3]} + (EW+MAN_W)'(inc);
    rnd_e     = rnd[EW+MAN_W-1:MAN_W];

    nan_a = (ea == '1) && (a_q[MAN_W-1:0] != '0);
    nan_b = (eb == '1) && (b_q[MAN_W-1:0] != '0);
    inf_a = (ea == '1) && (a_q[MAN_W-1:0] == '0);
    inf_b = (eb == '1) && (b_q[MAN_W-1:0] == '0);
    snan  = (nan_a && !a_q[MAN_W-1]) || (nan_b && !b_q[MAN_W-1]);

    res_d   = '0;
    flags_d = '0;
    if (nan_a || nan_b) begin
      res_d   = QNAN;
      flags_d = {snan, 2'b00};
    end else if (inf_a && inf_b && (a_q[W-1] != b_q[W-1])) begin
      res_d   = QNAN;
      flags_d = 3'b100;
    end else if (inf_a) begin
      res_d = {a_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      res_d = {b_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_q) begin
      res_d = {a_q[W-1] & b_q[W-1], {(W-1){1'b0}}};
    end else if (rnd_e >= EXP_MAX) begin
      res_d   = {big_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 3'b011;
    end else begin
      res_d   = {big_sign_q, rnd_e[EXP_W-1:0], rnd[MAN_W-1:0]};
      flags_d = {2'b00, inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= {b[W-1] ^ op, b[W-2:0]};
          state_q <= S_ALIGN;
        end
        S_ALIGN: begin
          big_sign_q <= big_sign_d;
          eff_sub_q  <= eff_sub_d;
          big_e_q    <= big_e_d;
          big_sig_q  <= big_sig_d;
          sml_sig_q  <= sml_sig_d;
          state_q    <= S_ADD;
        end
        S_ADD: begin
          sum_q   <= sum_d;
          state_q <= S_NORM;
        end
        S_NORM: begin
          norm_sig_q <= norm_sig_d;
          norm_e_q   <= norm_e_d;
          zero_q     <= zero_d;
          state_q    <= S_ROUND;
        end
        S_ROUND: begin
          result_q    <= res_d;
          flags_q     <= flags_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: doc/fpu_addsub.md
# fpu_addsub

Parametrised floating-point adder/subtractor for the FPU peripheral. It accepts two IEEE-754-style operands of configurable exponent and mantissa width, plus an add/subtract select. Results are rounded to nearest-even, and subnormals, infinities and NaN are handled fully. Exception flags are produced alongside each result. It sits behind the peripheral register interface and uses a valid/ready handshake on both input and output, so the register block can stall on a result.

## Interface
- EXP_W, default 5: exponent width; bias = 2^(EXP_W-1)-1.
- MAN_W, default 10: stored mantissa width; word width W = 1+EXP_W+MAN_W (16 by default).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  1  0 = a+b, 1 = a-b.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  W  rounded result.
- flags  out  3  {invalid, overflow, inexact}, valid with result.

## Operation
- The FSM states are IDLE → ALIGN → ADD → NORM → ROUND → DONE → IDLE.
- **IDLE:** in_ready=1. On in_valid&&in_ready the block registers a, b, op; it XORs op into b's sign; it goes to ALIGN.
- **ALIGN:** unpack both operands.
  - Exponent 0 means a subnormal: effective exponent 1, hidden bit 0. Otherwise the hidden bit is 1.
  - Swap operands so the larger magnitude is the big operand.
  - Right-shift the small significand by the exponent difference into an extended significand of MAN_W+4 bits (hidden, mantissa, G, R, S). Shifted-out bits OR into S.
  - The shift amount saturates at MAN_W+3.
  - Detect NaN (exp all ones, mantissa ≠0) and Inf (exp all ones, mantissa =0).
- **ADD:** same effective sign → add magnitudes, with one carry bit. Different signs → big − small, which is never negative after the swap. The result sign is the big operand's sign.
- **NORM:**
  - Carry set → shift right 1, keep sticky, exponent+1.
  - Otherwise, shift left by the leading-zero count. The shift is limited so the exponent does not drop below 1.
  - If the exponent reaches 1 with the hidden bit still 0, the result is subnormal and is encoded with exponent 0.
  - This is a single-cycle leading-zero count; there is no iterative shifting.
- **ROUND:** round to nearest-even using G, R, S and the LSB. inexact = G|R|S.
  - Round carry-out renormalises: exponent+1, significand becomes 1.000…
  - A subnormal that rounds up into hidden bit 1 becomes exponent 1.
  - Exponent ≥ all-ones after rounding → ±Inf, with overflow=1 and inexact=1.
- **Special cases, applied in priority order in ROUND:**
  1. Either operand NaN → canonical qNaN {0, all ones, 1 followed by MAN_W-1 zeros}, invalid=0 for quiet inputs.
  2. Inf + (−Inf) as effective operands → canonical qNaN, invalid=1.
  3. Any Inf → that Inf with its effective sign.
  4. Exact zero magnitude → +0, except both effective signs negative → −0.
- **DONE:** result and flags are registered, out_valid=1. On out_ready the FSM goes to IDLE. result and flags hold their values until the next DONE.

## Timing
- **Reset:** reset is sampled on a clk edge with rst_n=0. It forces state=IDLE, out_valid=0, result=0, flags=0. After that edge in_ready=1.
- **Reset mid-operation:** the operation is discarded and no out_valid is produced.
- **Latency:** acceptance occurs at edge T. out_valid is high after edge T+4, i.e. the 5th cycle after the accept cycle.
- **Throughput:** at most one operation per 6 cycles with out_ready tied high. in_ready is 0 from acceptance until return to IDLE.
- **Backpressure:** out_valid stays high and result and flags stay stable while out_ready=0, for unbounded time.
- **Acceptance:** in_valid while in_ready=0 is ignored. The source must hold its request until it sees in_ready.
- **Output handshake:** out_valid falls on the edge after out_valid&&out_ready. in_ready rises on that same edge.
- All outputs are registered, except in_ready, which is decoded from state.

## Test plan
- **Basic add and subtract:** 0x3C00 + 0x3C00 with op=0 → 0x4000, flags=000. 0x3C00 op=1 0x3C00 → 0x0000, flags=000.
- **Round to nearest-even ties:** 0x3C00 + 0x1000 (tie) → 0x3C00, flags=001. 0x3C01 + 0x1000 → 0x3C02, flags=001.
- **Overflow and subnormals:** 0x7BFF + 0x7BFF → 0x7C00, flags=011. 0x0001 + 0x0001 → 0x0002. 0x03FF + 0x0001 → 0x0400.
- **Specials:**
  - 0x7C00 op=1 0x7C00 → 0x7E00, flags=100.
  - 0x7E00 + 0x3C00 → 0x7E00, flags=000.
  - 0xFC00 + 0x3C00 → 0xFC00.
  - 0x8000 + 0x8000 → 0x8000.
- **Handshake and backpressure:** hold out_ready=0 for 3 cycles after out_valid. Required: result stable, in_ready=0, a second in_valid ignored. Then out_ready=1 for one cycle → out_valid=0 and in_ready=1 on the next cycle. Also check 4-cycle latency with out_ready=1.
- **Reset and parameters:** rst_n=0 in the ADD state → next cycle out_valid=0, result=0, in_ready=1, and no result later. Repeat cases 1–2 with EXP_W=8, MAN_W=23: 0x3F800000 + 0x3F800000 → 0x40000000.
